// File: rtl/xgmii2gmii_cvt.sv
// rtl/xgmii2gmii_cvt.sv - 64-bit XGMII-like word stream to GMII octet / MII nibble converter
module xgmii2gmii_cvt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mii_mode_i,
  output logic             ld_o,
  input  logic [63:0]      xd_i,
  input  logic [7:0]       xc_i,
  output logic             en_o,
  output logic             er_o,
  output logic [7:0]       d_o,
  output logic [CNT_W-1:0] frm_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERROR = 8'hFE;
  localparam logic [7:0] C_IDLE  = 8'h07;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FRAME = 1'b1;

  logic [3:0]  cnt;
  logic        mode_r;
  logic [63:0] hd;
  logic [7:0]  hc;
  logic [0:0]  state;
  logic [3:0]  hi_nib;

  logic [2:0]  lane;
  logic        nib_hi;
  logic [7:0]  oct;
  logic        ctl;

  logic        nx_en;
  logic        nx_er;
  logic [7:0]  nx_d;
  logic [0:0]  nx_state;
  logic        frm_inc;
  logic        err_inc;

  assign ld_o   = (cnt == (mode_r ? 4'd15 : 4'd7));
  // In MII each lane occupies two phases: even phase decodes, odd phase sends the high nibble
  assign lane   = mode_r ? cnt[3:1] : cnt[2:0];
  assign nib_hi = mode_r & cnt[0];
  assign oct    = hd[{lane, 3'b000} +: 8];
  assign ctl    = hc[lane];

  always_comb begin
    nx_en    = 1'b0;
    nx_er    = 1'b0;
    nx_d     = 8'h00;
    nx_state = state;
    frm_inc  = 1'b0;
    err_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!ctl) begin
          err_inc = 1'b1;
        end else if (oct == C_START) begin
          if (lane[1:0] == 2'b00) begin
            nx_en    = 1'b1;
            nx_d     = 8'h55;
            nx_state = S_FRAME;
          end else begin
            err_inc = 1'b1;
          end
        end else if (oct == C_ERROR) begin
          nx_er = 1'b1;
          nx_d  = 8'h0E;
        end
      end
      default: begin
        if (!ctl) begin
          nx_en = 1'b1;
          nx_d  = oct;
        end else if (oct == C_TERM) begin
          frm_inc  = 1'b1;
          nx_state = S_IDLE;
        end else if (oct == C_ERROR) begin
          nx_en   = 1'b1;
          nx_er   = 1'b1;
          nx_d    = C_ERROR;
          err_inc = 1'b1;
        end else begin
          nx_en    = 1'b1;
          nx_er    = 1'b1;
          nx_d     = oct;
          err_inc  = 1'b1;
          nx_state = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      mode_r    <= 1'b0;
      // Holding register starts as an all-IDLE word so the first pass is silent
      hd        <= {8{C_IDLE}};
      hc        <= 8'hFF;
      state     <= S_IDLE;
      hi_nib    <= 4'h0;
      en_o      <= 1'b0;
      er_o      <= 1'b0;
      d_o       <= 8'h00;
      frm_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      cnt <= ld_o ? 4'd0 : cnt + 4'd1;
      if (ld_o) begin
        hd     <= xd_i;
        hc     <= xc_i;
        mode_r <= mii_mode_i;
      end
      if (nib_hi) begin
        d_o <= {4'h0, hi_nib};
      end else begin
        en_o   <= nx_en;
        er_o   <= nx_er;
        d_o    <= mode_r ? {4'h0, nx_d[3:0]} : nx_d;
        hi_nib <= nx_d[7:4];
        state  <= nx_state;
        if (frm_inc && (frm_cnt_o != {CNT_W{1'b1}}))
          frm_cnt_o <= frm_cnt_o + 1'b1;
        if (err_inc && (err_cnt_o != {CNT_W{1'b1}}))
          err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/xgmii2gmii_cvt.md
Name: xgmii2gmii_cvt

Overview:
Converts the 64-bit XGMII-like stream (8 lanes, lane 0 = bits 7:0 = first octet) back into GMII (1000M) or MII (100M/10M) octet/nibble signalling. It is the transmit-side counterpart of the GMII/MII-to-XGMII converter. It sits between the PTP MAC-side datapath and a GE/FE PHY. It paces the wide side with a load strobe and serialises each word lane by lane.

Parameters:
CNT_W, 16, width of frame/error status counters (saturating)

Ports:
clk  input  1  system clock (GMII byte clock rate)
rst_n  input  1  reset; asynchronous, active-low
mii_mode_i  input  1  0: GE (1 octet/clk), 1: MII (1 nibble/clk)
ld_o  output  1  load strobe; xd_i/xc_i are sampled on the clk edge where ld_o=1
xd_i  input  64  XGMII-like data, lane k = bits 8k+7:8k
xc_i  input  8  XGMII-like control, bit k flags lane k as control character
en_o  output  1  GMII TX_EN / MII TX_EN
er_o  output  1  GMII TX_ER / MII TX_ER
d_o  output  8  GMII TXD; in MII mode only [3:0] are used, [7:4]=0
frm_cnt_o  output  CNT_W  frames completed with TERMINATE (saturating)
err_cnt_o  output  CNT_W  protocol errors detected (saturating)

Behaviour:
- Control characters: START=8'hFB, TERMINATE=8'hFD, ERROR=8'hFE, IDLE=8'h07 (project defines).
- Reset: en_o=0, er_o=0, d_o=0, ld_o=0, counters=0, state IDLE, phase counter=0, mode register=0.
- Phase counter: 4 bits, free-running. GE wraps at 7; MII wraps at 15. ld_o=1 combinationally when the counter equals its wrap value.
- mii_mode_i is latched into a mode register only on ld_o edges. A mode change never splits a word.
- On an ld_o edge the word is captured into a holding register.
- GE output timing: lane k drives the outputs registered at edge E+1+k, where E is the capture edge.
- MII output timing: lane k low nibble is output at edge E+1+2k and the high nibble at edge E+2+2k.
- Throughput: one word per 8 clks (GE) or 16 clks (MII), with no gaps.
- Lane decode FSM, states IDLE and FRAME, evaluated once per lane:
  - IDLE, control START, lane 0 or 4: en=1, er=0, d=8'h55 (START replaces the first preamble octet); go to FRAME.
  - IDLE, control START, lanes 1-3 or 5-7: en=0; err_cnt+1; stay in IDLE.
  - IDLE, data octet: en=0; err_cnt+1.
  - IDLE, control ERROR: en=0, er=1, d=8'h0E (false-carrier indication).
  - IDLE, other control: en=0, er=0, d=0.
  - FRAME, data octet: en=1, er=0, d=octet.
  - FRAME, control TERMINATE: en=0, er=0, d=0; frm_cnt+1; go to IDLE. Remaining lanes of the word are decoded in IDLE.
  - FRAME, control ERROR: en=1, er=1, d=8'hFE; err_cnt+1; stay in FRAME.
  - FRAME, control IDLE, START or any other code: en=1, er=1, d=octet; err_cnt+1; go to IDLE on the next lane (frame aborted with error).
- MII nibbles: both nibbles of a lane carry the same en/er.
  - Low nibble first, then high nibble.
  - START lane produces nibbles 5,5 (octet 8'h55).
- Counters saturate at all-ones and never wrap. A TERMINATE and an error event in the same lane increment both counters.
- Reset mid-frame: immediate return to reset values. The partially sent frame is truncated and not counted.

Test Plan:
1. GE, word0 {xc=8'h01, lane0=FB, lanes1-6=55, lane7=D5}, word1 all data 00..07, word2 {lane0=FD, rest IDLE} -> en_o high for 16 clks, d_o = 55×7, D5, 00..07; en_o falls at the word2 lane0 slot; frm_cnt_o=1.
2. GE, START in lane 4 of word0 -> en_o first rises 5 clks after the capture edge with d_o=55. START in lane 2 -> en_o stays 0 and err_cnt_o=1.
3. GE, ERROR control inside a frame at lane 3 -> that cycle shows en_o=1, er_o=1, d_o=FE; the frame continues; err_cnt_o increments by 1.
4. MII mode, same stimulus as test 1 -> ld_o period is 16 clks; d_o[3:0] = 5,5 repeated then 5,D for the SFD; 0,0,1,0,... for the data; d_o[7:4]=0; frm_cnt_o=1.
5. Toggle mii_mode_i mid-word -> the current word completes at the old rate; the new rate starts at the next ld_o.
6. Assert rst_n low during a frame's data lanes -> all outputs 0 asynchronously. After release, IDLE words give en_o=0, and the next START begins cleanly with the counters at 0.
